regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_OF_SETS, default 32, meaning the number of register-file entries (power of two, at least 2).
REQ-002 The block SHALL take parameter DATA_BUS_WIDTH, default 32, meaning the write-data width; AW = $clog2(NUM_OF_SETS).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port a_valid, input, 1 bit: requester A (ALU writeback) has a write pending.
REQ-006 The block SHALL have port a_ready, output, 1 bit: requester A's write is accepted this cycle.
REQ-007 The block SHALL have ports a_addr (input, AW bits) and a_data (input, DATA_BUS_WIDTH bits): requester A's target entry and write data.
REQ-008 The block SHALL have ports b_valid, b_ready, b_addr and b_data, with the same widths and meanings as REQ-005 to REQ-007, for requester B (load writeback).
REQ-009 The block SHALL have port rf_wr_enable, output, 1 bit: register-file write strobe.
REQ-010 The block SHALL have ports rf_wr_addr (output, AW bits) and rf_wr_data (output, DATA_BUS_WIDTH bits): register-file write address and data.
REQ-011 The block SHALL have port init_done, output, 1 bit: the clear sweep is complete and arbitration is active.
REQ-012 The block SHALL have port last_grant, output, 1 bit: 0 means A was granted last, 1 means B was granted last.

Function
REQ-013 The block SHALL have two states: INIT (clear sweep) and ARB (arbitration).
REQ-014 rf_wr_enable, rf_wr_addr, rf_wr_data, init_done and last_grant SHALL all be registers.
REQ-015 a_ready and b_ready SHALL be combinational from the state, last_grant, a_valid and b_valid.
REQ-016 In INIT, each rising edge with rst=1 SHALL register rf_wr_enable=1, rf_wr_addr=counter and rf_wr_data=0, then increment the counter.
REQ-017 The clear sweep SHALL cover addresses 0..NUM_OF_SETS-1 in ascending order, one address per cycle, with no gaps.
REQ-018 On the edge after address NUM_OF_SETS-1 is issued, the block SHALL register init_done=1 and rf_wr_enable=0 and enter ARB.
REQ-019 init_done SHALL remain 1 until the next reset.
REQ-020 In INIT, a_ready and b_ready SHALL be 0, and a_valid and b_valid SHALL be ignored.
REQ-021 In ARB with only one valid asserted, that requester SHALL receive ready=1 in the same cycle.
REQ-022 In ARB with both valids asserted, ready SHALL go to the requester not named by last_grant (round-robin); the other requester's ready SHALL be 0.
REQ-023 At most one ready SHALL be 1 in any cycle; ready SHALL be 0 whenever the corresponding valid is 0.
REQ-024 A transfer SHALL occur when valid=1 and ready=1; on that edge, last_grant SHALL update to the granted requester.
REQ-025 A transfer SHALL produce rf_wr_enable=1, with the granted address and data, on the following cycle (latency 1).
REQ-026 Throughput SHALL be one transfer per cycle, sustained.
REQ-027 Without a transfer, rf_wr_enable SHALL be 0 on the next cycle.
REQ-028 A transfer with address 0 SHALL complete its handshake and update last_grant, but SHALL leave rf_wr_enable=0 (entry 0 is hardwired zero).
REQ-029 Requesters SHALL hold valid, addr and data stable until their transfer; the arbiter adds no buffering beyond the one output register stage.
REQ-030 Under continuous contention, neither requester SHALL wait more than 1 cycle between grants.

Reset
REQ-031 When rst=0 at a rising edge, the block SHALL register rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0, init_done=0, last_grant=1 and counter=0, and SHALL enter INIT.
REQ-032 While rst=0, a_ready and b_ready SHALL be 0.
REQ-033 Reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-034 Reset asserted in ARB SHALL discard any transfer in the same cycle and suppress its write.
REQ-035 Because last_grant resets to 1 (B), A SHALL win the first contended cycle after init.

Verification
REQ-036 Reset release, NUM_OF_SETS=32 -> rf_wr_enable=1 for exactly 32 consecutive cycles with addresses 0..31 and data 0; init_done=1 on the next cycle; both readies 0 throughout the sweep.
REQ-037 ARB, a_valid=1, a_addr=5, a_data=32'hDEADBEEF, b_valid=0 -> a_ready=1 in the same cycle; next cycle rf_wr_enable=1, rf_wr_addr=5, rf_wr_data=32'hDEADBEEF.
REQ-038 ARB, both valids held, A addr 1 data 32'h11 and B addr 2 data 32'h22, for 4 transfers -> grant order A,B,A,B; writes to addresses 1,2,1,2; last_grant sequence 0,1,0,1.
REQ-039 b_valid=1, b_addr=0, b_data=32'hFFFFFFFF, a_valid=0 -> b_ready=1 and last_grant=1; next cycle rf_wr_enable=0.
REQ-040 rst=0 during sweep address 10 for 1 cycle -> next cycle rf_wr_enable=0 and init_done=0; the sweep then restarts at address 0.
REQ-041 rst=0 in the same cycle as an A transfer to address 7 -> no write to address 7; all outputs take reset values; the block re-enters INIT.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: clears the register file after reset, then round-robin arbitrates two writeback ports
module regfile_wr_arbiter #(
    parameter int NUM_OF_SETS = 32,
    parameter int DATA_BUS_WIDTH = 32,
    localparam int AW = $clog2(NUM_OF_SETS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [AW-1:0]             a_addr,
    input  logic [DATA_BUS_WIDTH-1:0] a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [AW-1:0]             b_addr,
    input  logic [DATA_BUS_WIDTH-1:0] b_data,
    output logic                      rf_wr_enable,
    output logic [AW-1:0]             rf_wr_addr,
    output logic [DATA_BUS_WIDTH-1:0] rf_wr_data,
    output logic                      init_done,
    output logic                      last_grant
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] ARB  = 1'b1;
    logic [0:0]                state_q, state_d;
    logic [AW:0]               cnt_q, cnt_d;
    logic                      wr_en_q, wr_en_d;
    logic [AW-1:0]             wr_addr_q, wr_addr_d;
    logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      done_q, done_d;
    logic                      last_q, last_d;
    logic                      arb_on;
    assign arb_on  = rst && state_q == ARB;
    assign a_ready = arb_on && a_valid && (!b_valid || last_q);
    assign b_ready = arb_on && b_valid && (!a_valid || !last_q);
    assign rf_wr_enable = wr_en_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_wr_data   = wr_data_q;
    assign init_done    = done_q;
    assign last_grant   = last_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        last_d    = last_q;
        if (state_q == INIT) begin
            // counter carries one extra bit so the cycle after the last address is distinguishable
            if (cnt_q[AW]) begin
                state_d = ARB;
                done_d  = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q[AW-1:0];
                wr_data_d = '0;
                cnt_d     = cnt_q + 1'b1;
            end
        end else if (a_ready) begin
            wr_en_d   = |a_addr;
            wr_addr_d = a_addr;
            wr_data_d = a_data;
            last_d    = 1'b0;
        end else if (b_ready) begin
            wr_en_d   = |b_addr;
            wr_addr_d = b_addr;
            wr_data_d = b_data;
            last_d    = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            last_q    <= last_d;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed vectors checked against a behavioural model and literal expectations
module tb_regfile_wr_arbiter;
    localparam int N = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic a_ready, b_ready;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic rf_wr_enable, init_done, last_grant;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    int n_tests = 0;
    int n_fail = 0;
    regfile_wr_arbiter #(.NUM_OF_SETS(N), .DATA_BUS_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .init_done(init_done), .last_grant(last_grant)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    bit m_armed = 0;
    bit m_done, m_last, m_en;
    int m_next;
    int m_addr;
    logic [DW-1:0] m_data;
    function automatic int winner(input bit av, input bit bv, input bit last);
        if (av && bv) return last ? 1 : 2;
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction
    always @(posedge clk) begin
        int g;
        g = m_done ? winner(a_valid, b_valid, m_last) : 0;
        if (!rst) begin
            m_armed = 1;
            m_done = 0;
            m_last = 1;
            m_next = 0;
            m_en = 0;
            m_addr = 0;
            m_data = '0;
        end else if (!m_done) begin
            if (m_next < N) begin
                m_en = 1;
                m_addr = m_next;
                m_data = '0;
                m_next++;
            end else begin
                m_en = 0;
                m_done = 1;
            end
        end else if (g == 1) begin
            m_en = a_addr != 0;
            m_addr = int'(a_addr);
            m_data = a_data;
            m_last = 0;
        end else if (g == 2) begin
            m_en = b_addr != 0;
            m_addr = int'(b_addr);
            m_data = b_data;
            m_last = 1;
        end else m_en = 0;
    end
    always @(negedge clk) begin
        int g;
        if (m_armed) begin
            g = (rst && m_done) ? winner(a_valid, b_valid, m_last) : 0;
            check("model a_ready", 64'(a_ready), 64'(g == 1));
            check("model b_ready", 64'(b_ready), 64'(g == 2));
            check("model wr_en", 64'(rf_wr_enable), 64'(m_en));
            check("model init_done", 64'(init_done), 64'(m_done));
            check("model last_grant", 64'(last_grant), 64'(m_last));
            if (m_en) begin
                check("model wr_addr", 64'(rf_wr_addr), 64'(m_addr));
                check("model wr_data", 64'(rf_wr_data), 64'(m_data));
            end
        end
    end
    task automatic go;
        @(posedge clk);
        #2;
    endtask
    initial begin
        go; go; go;
        @(negedge clk);
        check("reset wr_en", 64'(rf_wr_enable), 0);
        check("reset init_done", 64'(init_done), 0);
        check("reset last_grant", 64'(last_grant), 1);
        check("reset a_ready", 64'(a_ready), 0);
        go;
        rst = 1; a_valid = 1; b_valid = 1; a_addr = 3; b_addr = 4;
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("sweep wr_en", 64'(rf_wr_enable), 1);
            check("sweep addr", 64'(rf_wr_addr), 64'(i));
            check("sweep data", 64'(rf_wr_data), 0);
            check("sweep readies", 64'({a_ready, b_ready}), 0);
        end
        @(posedge clk);
        #2 a_valid = 0; b_valid = 0;
        @(negedge clk);
        check("sweep end init_done", 64'(init_done), 1);
        check("sweep end wr_en", 64'(rf_wr_enable), 0);
        go;
        a_valid = 1; a_addr = 1; a_data = 32'h11;
        b_valid = 1; b_addr = 2; b_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr a_ready", 64'(a_ready), 64'(k % 2 == 0));
            check("rr b_ready", 64'(b_ready), 64'(k % 2 == 1));
            if (k > 0) begin
                check("rr wr_addr", 64'(rf_wr_addr), (k % 2 == 1) ? 1 : 2);
                check("rr last_grant", 64'(last_grant), (k % 2 == 1) ? 0 : 1);
            end
            go;
        end
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        check("rr final addr", 64'(rf_wr_addr), 2);
        check("rr final last_grant", 64'(last_grant), 1);
        go;
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
        @(negedge clk);
        check("solo a_ready", 64'(a_ready), 1);
        go;
        a_valid = 0;
        @(negedge clk);
        check("solo wr_en", 64'(rf_wr_enable), 1);
        check("solo wr_addr", 64'(rf_wr_addr), 5);
        check("solo wr_data", 64'(rf_wr_data), 64'h DEADBEEF);
        go;
        b_valid = 1; b_addr = 0; b_data = 32'hFFFFFFFF;
        @(negedge clk);
        check("zero b_ready", 64'(b_ready), 1);
        go;
        b_valid = 0;
        @(negedge clk);
        check("zero wr_en", 64'(rf_wr_enable), 0);
        check("zero last_grant", 64'(last_grant), 1);
        go;
        a_valid = 1; a_addr = 7; a_data = 32'h77; rst = 0;
        @(negedge clk);
        check("rst arb a_ready", 64'(a_ready), 0);
        go;
        rst = 1; a_valid = 0;
        @(negedge clk);
        check("rst arb wr_en", 64'(rf_wr_enable), 0);
        check("rst arb init_done", 64'(init_done), 0);
        check("rst arb last_grant", 64'(last_grant), 1);
        check("rst arb addr", 64'(rf_wr_addr), 0);
        go;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            check("resweep addr", 64'(rf_wr_addr), 64'(i));
            if (i < 10) go;
        end
        #1 rst = 0;
        go;
        rst = 1;
        @(negedge clk);
        check("midsweep rst wr_en", 64'(rf_wr_enable), 0);
        check("midsweep rst init_done", 64'(init_done), 0);
        go;
        @(negedge clk);
        check("restart addr", 64'(rf_wr_addr), 0);
        check("restart wr_en", 64'(rf_wr_enable), 1);
        for (int i = 0; i < 80; i++) begin
            go;
            a_valid = (i % 3) != 0;
            b_valid = (i % 4) != 1;
            a_addr = AW'(i);
            b_addr = AW'(i * 7);
            a_data = 32'hA000_0000 + i;
            b_data = 32'hB000_0000 + i;
        end
        go;
        a_valid = 0; b_valid = 0;
        go; go;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
